// File: rtl/bcd_seg7_scan.sv
// Two-digit multiplexed seven-segment driver with input settling filter,
// inter-digit blanking and leading-zero suppression. Optional blink: SEG7_BLINK_EN.
module bcd_seg7_scan #(
  parameter int REFRESH_DIV   = 50000,
  parameter int GAP_CYCLES    = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int BLINK_DIV     = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       blank_lz,
`ifdef SEG7_BLINK_EN
  input  logic       blink,
`endif
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int SLOT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int SLOT_W   = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;
  localparam int STAB_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [SLOT_W-1:0] ACT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] GAP_LAST = SLOT_W'(GAP_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {T_ACT, T_GAP, O_ACT, O_GAP} state_t;

  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'b0111111;
    endcase
    return g;
  endfunction

  logic [7:0]        r_prev;
  logic [STAB_W-1:0] r_stab_cnt;
  logic [3:0]        r_disp_t;
  logic [3:0]        r_disp_o;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [SLOT_W-1:0] r_slot_cnt;
  logic [SLOT_W-1:0] w_slot_nxt;
  logic              w_slot_last;
  logic              w_hide;
  logic [6:0]        w_seg_nxt;
  logic [1:0]        w_an_nxt;

  // Input settling filter: digits load only after the pair has held steady
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev     <= 8'h00;
      r_stab_cnt <= '0;
      r_disp_t   <= 4'd0;
      r_disp_o   <= 4'd0;
    end else begin
      r_prev <= {tens, ones};
      if ({tens, ones} != r_prev) begin
        r_stab_cnt <= '0;
      end else if (r_stab_cnt != STAB_MAX) begin
        r_stab_cnt <= r_stab_cnt + STAB_W'(1);
      end else begin
        r_stab_cnt <= r_stab_cnt;
      end
      if (r_stab_cnt == STAB_MAX) begin
        r_disp_t <= r_prev[7:4];
        r_disp_o <= r_prev[3:0];
      end else begin
        r_disp_t <= r_disp_t;
        r_disp_o <= r_disp_o;
      end
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;

  // Blink half-period timer; held at the visible phase while blink is off
  always_ff @(posedge clk) begin
    if (!rst || !blink) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + BLINK_W'(1);
      r_blink_phase <= r_blink_phase;
    end
  end

  assign w_hide = blink & r_blink_phase;
`else
  assign w_hide = 1'b0;
`endif

  // Scan state and slot counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= T_ACT;
      r_slot_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_slot_cnt <= w_slot_nxt;
    end
  end

  // Scan next-state: each state lasts its slot length, then advances
  always_comb begin
    w_state_nxt = r_state;
    w_slot_last = 1'b0;
    case (r_state)
      T_ACT: begin
        w_slot_last = (r_slot_cnt == ACT_LAST);
        w_state_nxt = w_slot_last ? T_GAP : T_ACT;
      end
      T_GAP: begin
        w_slot_last = (r_slot_cnt == GAP_LAST);
        w_state_nxt = w_slot_last ? O_ACT : T_GAP;
      end
      O_ACT: begin
        w_slot_last = (r_slot_cnt == ACT_LAST);
        w_state_nxt = w_slot_last ? O_GAP : O_ACT;
      end
      O_GAP: begin
        w_slot_last = (r_slot_cnt == GAP_LAST);
        w_state_nxt = w_slot_last ? T_ACT : O_GAP;
      end
      default: begin
        w_slot_last = 1'b1;
        w_state_nxt = T_ACT;
      end
    endcase
    if (w_slot_last) begin
      w_slot_nxt = '0;
    end else begin
      w_slot_nxt = r_slot_cnt + SLOT_W'(1);
    end
  end

  // Output selection for the current slot, registered below
  always_comb begin
    w_seg_nxt = 7'h7F;
    w_an_nxt  = 2'b11;
    case (r_state)
      T_ACT: begin
        if (!w_hide && !(blank_lz && (r_disp_t == 4'd0))) begin
          w_seg_nxt = seg7_decode(r_disp_t);
          w_an_nxt  = 2'b01;
        end else begin
          w_seg_nxt = 7'h7F;
          w_an_nxt  = 2'b11;
        end
      end
      O_ACT: begin
        if (!w_hide) begin
          w_seg_nxt = seg7_decode(r_disp_o);
          w_an_nxt  = 2'b10;
        end else begin
          w_seg_nxt = 7'h7F;
          w_an_nxt  = 2'b11;
        end
      end
      default: begin
        w_seg_nxt = 7'h7F;
        w_an_nxt  = 2'b11;
      end
    endcase
  end

  // Registered display pins
  always_ff @(posedge clk) begin
    if (!rst) begin
      seg <= 7'h7F;
      an  <= 2'b11;
    end else begin
      seg <= w_seg_nxt;
      an  <= w_an_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Directed self-checking bench for bcd_seg7_scan with a 12-cycle scan period.
module tb_bcd_seg7_scan;

  logic       clk;
  logic       rst;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       blank_lz;
  logic       blink;
  logic [6:0] seg;
  logic [1:0] an;

  int tests_run = 0;
  int tests_failed = 0;
  int n_edges = 0;

  logic [6:0] glyph [16];

  bcd_seg7_scan #(
    .REFRESH_DIV(4), .GAP_CYCLES(2), .STABLE_CYCLES(2), .BLINK_DIV(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tens(tens),
    .ones(ones),
    .blank_lz(blank_lz),
`ifdef SEG7_BLINK_EN
    .blink(blink),
`endif
    .seg(seg),
    .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got {an,seg}=%h expected %h", tag, got, exp);
    end
  endtask

  // Steps cnt edges after reset release; expected outputs come from slot position
  task automatic run_cycles(input int cnt, input logic [3:0] t, input logic [3:0] o,
                            input logic lz, input logic hide);
    int pos;
    logic [8:0] exp;
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk);
      @(negedge clk);
      pos = n_edges % 12;
      n_edges++;
      if (pos < 4) begin
        exp = (hide || (lz && t == 4'd0)) ? {2'b11, 7'h7F} : {2'b01, glyph[t]};
      end else if (pos >= 6 && pos < 10) begin
        exp = hide ? {2'b11, 7'h7F} : {2'b10, glyph[o]};
      end else begin
        exp = {2'b11, 7'h7F};
      end
      check_eq($sformatf("scan_edge%0d_pos%0d", n_edges, pos), {an, seg}, exp);
    end
  endtask

  initial begin
    glyph[0] = 7'h40; glyph[1] = 7'h79; glyph[2] = 7'h24; glyph[3] = 7'h30;
    glyph[4] = 7'h19; glyph[5] = 7'h12; glyph[6] = 7'h02; glyph[7] = 7'h78;
    glyph[8] = 7'h00; glyph[9] = 7'h10;
    for (int i = 10; i < 16; i++) glyph[i] = 7'b0111111;

    rst = 1'b0; tens = 4'd0; ones = 4'd0; blank_lz = 1'b0; blink = 1'b0;

    // 1: reset then default "00" scan
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("reset_hold", {an, seg}, {2'b11, 7'h7F});
    end
    rst = 1'b1;
    n_edges = 0;
    run_cycles(24, 4'd0, 4'd0, 1'b0, 1'b0);

    // 2: 42 loads three edges after the change, visible one edge later
    tens = 4'd4; ones = 4'd2;
    run_cycles(4, 4'd0, 4'd0, 1'b0, 1'b0);
    run_cycles(12, 4'd4, 4'd2, 1'b0, 1'b0);

    // 3: transient ones values never reach the display
    ones = 4'd3; run_cycles(1, 4'd4, 4'd2, 1'b0, 1'b0);
    ones = 4'd4; run_cycles(1, 4'd4, 4'd2, 1'b0, 1'b0);
    ones = 4'd5; run_cycles(1, 4'd4, 4'd2, 1'b0, 1'b0);
    ones = 4'd7; run_cycles(4, 4'd4, 4'd2, 1'b0, 1'b0);
    run_cycles(12, 4'd4, 4'd7, 1'b0, 1'b0);

    // 4: leading-zero blanking, blank_lz acts immediately
    blank_lz = 1'b1; tens = 4'd0; ones = 4'd9;
    run_cycles(4, 4'd4, 4'd7, 1'b1, 1'b0);
    run_cycles(12, 4'd0, 4'd9, 1'b1, 1'b0);

    // 5: invalid tens shows a dash; then reset in the middle of O_ACT
    blank_lz = 1'b0; tens = 4'd12;
    run_cycles(4, 4'd0, 4'd9, 1'b0, 1'b0);
    run_cycles(12, 4'd12, 4'd9, 1'b0, 1'b0);
    while ((n_edges % 12) != 7) run_cycles(1, 4'd12, 4'd9, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("reset_mid_oact", {an, seg}, {2'b11, 7'h7F});
    @(posedge clk);
    @(negedge clk);
    check_eq("reset_mid_hold", {an, seg}, {2'b11, 7'h7F});
    rst = 1'b1;
    n_edges = 0;
    run_cycles(4, 4'd0, 4'd0, 1'b0, 1'b0);
    run_cycles(12, 4'd12, 4'd9, 1'b0, 1'b0);

`ifdef SEG7_BLINK_EN
    // 6: blink alternates 8 visible / 8 blank, release restores at once
    tens = 4'd4; ones = 4'd2;
    run_cycles(4, 4'd12, 4'd9, 1'b0, 1'b0);
    run_cycles(8, 4'd4, 4'd2, 1'b0, 1'b0);
    blink = 1'b1;
    run_cycles(8, 4'd4, 4'd2, 1'b0, 1'b0);
    run_cycles(8, 4'd4, 4'd2, 1'b0, 1'b1);
    run_cycles(8, 4'd4, 4'd2, 1'b0, 1'b0);
    run_cycles(3, 4'd4, 4'd2, 1'b0, 1'b1);
    blink = 1'b0;
    run_cycles(12, 4'd4, 4'd2, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bcd_seg7_scan.md
# bcd_seg7_scan

Two-digit multiplexed seven-segment display driver that consumes the `tens`/`ones` BCD digits from the binary-to-BCD converter. It filters out transient digit values while the converter is iterating, then decodes and time-multiplexes the two digits onto a shared active-low segment bus. Blanking gaps between digits prevent ghosting, and optional leading-zero suppression is supported. It sits between the converter and the board's display pins.

## Interface
Parameters:
- `REFRESH_DIV`, 50000: clk cycles each digit is driven (active slot); legal ≥ 1.
- `GAP_CYCLES`, 4: clk cycles with both anodes off after each active slot; legal ≥ 1.
- `STABLE_CYCLES`, 2: consecutive unchanged cycles required before an input pair is accepted; legal ≥ 1.
- `BLINK_DIV`, 25000000: blink half-period in clk cycles; used only with `SEG7_BLINK_EN`.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: synchronous, active-low reset.
- `tens`, input, 4: BCD tens digit from the converter.
- `ones`, input, 4: BCD ones digit from the converter.
- `blank_lz`, input, 1: when 1, an accepted tens value of 0 is not displayed.
- `blink`, input, 1: present only with `SEG7_BLINK_EN`; 1 enables blinking.
- `seg`, output, 7: segments {g,f,e,d,c,b,a}, active low. `seg[0]` is a.
- `an`, output, 2: digit enables, active low. `an[1]` is tens and `an[0]` is ones.

## Operation
- **Input filter.** `prev` samples `{tens,ones}` on every edge.
  - `stab_cnt` clears when input ≠ `prev`. Otherwise it increments and saturates at `STABLE_CYCLES`.
  - When `stab_cnt == STABLE_CYCLES`, `disp_t`/`disp_o` load from `prev`.
- **Scan FSM.** Four states: `T_ACT` → `T_GAP` → `O_ACT` → `O_GAP` → `T_ACT`.
  - `slot_cnt` counts 0 to N−1 in each state and then advances the state.
  - N is `REFRESH_DIV` in the ACT states and `GAP_CYCLES` in the GAP states.
- **Decode.** Digits 0–9 map to the standard glyphs, e.g. 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
  - Codes 10–15 (invalid BCD) display a dash, 7'b0111111.
- **Outputs are registered.**
  - `T_ACT`: `an`=2'b01 and `seg`=decode(`disp_t`).
  - `O_ACT`: `an`=2'b10 and `seg`=decode(`disp_o`).
  - GAP states: `an`=2'b11 and `seg`=7'h7F.
- **Leading-zero blanking.** When `blank_lz`=1 and `disp_t`==0, `T_ACT` drives `an`=2'b11 and `seg`=7'h7F. Slot timing is unchanged.
- **Mid-slot digit change.** If `disp_*` changes during an active slot, `seg` shows the new glyph from the next cycle. The slot is not restarted.

## Timing
- **Reset** (rst=0 at an edge):
  - `seg`=7'h7F and `an`=2'b11.
  - State = `T_ACT`, `slot_cnt`=0, `stab_cnt`=0.
  - `prev`, `disp_t` and `disp_o` = 0.
- **After reset release:** the first edge with rst=1 drives tens-slot outputs, so the display shows "00", or the ones digit only when `blank_lz`=1.
- **Reset mid-slot:** takes effect at that edge regardless of state or counters.
- **Filter latency:** a value first present at edge k loads `disp_*` at edge k+`STABLE_CYCLES`+1. Any change before then restarts the count.
- **Output latency:** one cycle from state or `disp_*` to `seg`/`an`.
- **Scan period:** 2·(`REFRESH_DIV`+`GAP_CYCLES`) cycles.
- **Counter widths:** `slot_cnt` is sized by `$clog2` of max(`REFRESH_DIV`, `GAP_CYCLES`) and wraps only through the state transition. `stab_cnt` never wraps.
- **Simultaneous events:**
  - A `disp_*` load on the same edge as a slot transition is honoured; the new state decodes the new value.
  - `blank_lz` is sampled every cycle with no filtering.

## Configuration
- **`SEG7_BLINK_EN` defined:**
  - Adds the `blink` port and a `BLINK_DIV` counter that toggles `blink_phase`.
  - While `blink`=1 and `blink_phase`=1, both active slots drive `an`=2'b11 and `seg`=7'h7F.
  - The scan FSM keeps running.
  - The blink counter resets to 0, phase 0 (visible), and clears whenever `blink`=0.
- **Not defined:** no `blink` port and no blink logic. The display is always visible, subject only to `blank_lz`.

## Test plan
Parameters: `REFRESH_DIV`=4, `GAP_CYCLES`=2, `STABLE_CYCLES`=2, `BLINK_DIV`=8.
1. Hold rst=0 for 3 cycles, then release with tens=0, ones=0 and `blank_lz`=0.
   - During reset: `seg`=7'h7F and `an`=2'b11.
   - Then: 4 cycles of `an`=2'b01 with `seg`=7'h40, 2 cycles of `an`=2'b11, 4 cycles of `an`=2'b10 with `seg`=7'h40, then repeating with period 12.
2. Hold tens=4, ones=2 steady.
   - `disp` loads 3 edges after the change.
   - Tens slot shows `seg`=7'b0011001 and ones slot shows `seg`=7'b0100100.
3. Drive ones=3, 4, 5 on three consecutive cycles, then hold 7.
   - `disp_o` never holds 3 or 4.
   - It becomes 7 exactly 3 edges after 7 first appears.
4. Set `blank_lz`=1 with tens=0, ones=9.
   - Tens slot: `an`=2'b11. Ones slot: `an`=2'b10, `seg`=7'b0010000.
   - Slot timing is unchanged.
5. Drive tens=12 (invalid).
   - Tens slot shows `seg`=7'b0111111.
   - Also assert rst=0 mid-`O_ACT`: outputs go blank at that edge and the scan restarts in `T_ACT`.
6. (`SEG7_BLINK_EN`) Drive `blink`=1 with digits 42.
   - Digits are visible for 8 cycles, blank for 8, visible for 8.
   - Deasserting `blink` restores display on the next cycle.
